pmem_burst_arbiter: RTL

//  Shares one burst physical-memory port between the I-cache (line reads) and the D-cache
//  (line reads/writebacks). Grants one requester at a time and splits or assembles

---
 rtl/pmem_burst_arbiter_if.sv | 45 ++++
 rtl/pmem_burst_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pmem_burst_arbiter_if.sv
// Bundle of the cache-side and memory-side signals of the burst arbiter.
// master drives requests and memory responses; slave is the arbiter itself.
interface pmem_burst_arbiter_if #(
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int BURST_LEN        = 4,
    parameter int ADDR_WIDTH       = 32
);
    localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;

    logic                        i_read;
    logic [ADDR_WIDTH-1:0]       i_addr;
    logic [CACHE_LINE_WIDTH-1:0] i_rdata;
    logic                        i_resp;

    logic                        d_read;
    logic                        d_write;
    logic [ADDR_WIDTH-1:0]       d_addr;
    logic [CACHE_LINE_WIDTH-1:0] d_wdata;
    logic [CACHE_LINE_WIDTH-1:0] d_rdata;
    logic                        d_resp;

    logic                        pmem_read;
    logic                        pmem_write;
    logic [ADDR_WIDTH-1:0]       pmem_addr;
    logic [BURST_WIDTH-1:0]      pmem_wdata;
    logic [BURST_WIDTH-1:0]      pmem_rdata;
    logic                        pmem_resp;
    logic                        pmem_error;

    logic                        arb_error;

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
               pmem_rdata, pmem_resp, pmem_error,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_addr, pmem_wdata, arb_error
    );

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
               pmem_rdata, pmem_resp, pmem_error,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_addr, pmem_wdata, arb_error
    );
endinterface

// File: rtl/pmem_burst_arbiter.sv
// Shares one burst pmem port between I-cache and D-cache, splitting/assembling lines into beats.
// Optional ARB_ROUND_ROBIN_EN: on a simultaneous request grant the side not served last.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | sample requests, grant one, latch line address and write data
// I_RD  | burst read for the I-cache, collecting beats into line buffer
// D_RD  | burst read for the D-cache, collecting beats into line buffer
// D_WR  | burst write of the D-cache line, one beat per pmem_resp
// DONE  | one-cycle response pulse to the granted cache
module pmem_burst_arbiter #(
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int BURST_LEN        = 4,
    parameter int ADDR_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pmem_burst_arbiter_if.slave   bus
);
    localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;
    localparam int OFS         = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int CW          = $clog2(BURST_LEN) + 1;
    localparam int IW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CW-1:0]         LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1));

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] I_RD = 3'd1;
    localparam logic [2:0] D_RD = 3'd2;
    localparam logic [2:0] D_WR = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]                  state;
    logic [CW-1:0]               beat;
    logic [CACHE_LINE_WIDTH-1:0] line_buf;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic                        pmem_read_q;
    logic                        pmem_write_q;
    logic                        i_resp_q;
    logic                        d_resp_q;
    logic                        arb_error_q;
    logic                        last_d;

    logic                        i_req;
    logic                        d_req;
    logic                        pick_d;
    logic [IW-1:0]               beat_idx;
    logic                        in_burst;

    always_comb begin
        i_req    = bus.i_read;
        d_req    = bus.d_read | bus.d_write;
`ifdef ARB_ROUND_ROBIN_EN
        // last_d remembers who completed most recently; a tie goes to the other side
        pick_d   = d_req & (~i_req | ~last_d);
`else
        pick_d   = d_req;
`endif
        beat_idx = beat[IW-1:0];
        in_burst = (state == I_RD) || (state == D_RD) || (state == D_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat         <= '0;
            line_buf     <= '0;
            addr_q       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
            arb_error_q  <= 1'b0;
            last_d       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        beat     <= '0;
                        line_buf <= bus.d_wdata;
                        addr_q   <= (pick_d ? bus.d_addr : bus.i_addr) & LINE_MASK;
                        if (pick_d && bus.d_write) begin
                            state        <= D_WR;
                            pmem_write_q <= 1'b1;
                        end else begin
                            state       <= pick_d ? D_RD : I_RD;
                            pmem_read_q <= 1'b1;
                        end
                    end
                end
                I_RD, D_RD, D_WR: begin
                    if (bus.pmem_error) begin
                        state        <= IDLE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        arb_error_q  <= 1'b1;
                    end else if (bus.pmem_resp) begin
                        if (state != D_WR) begin
                            line_buf[beat_idx*BURST_WIDTH +: BURST_WIDTH] <= bus.pmem_rdata;
                        end
                        if (beat == LAST_BEAT) begin
                            state        <= DONE;
                            pmem_read_q  <= 1'b0;
                            pmem_write_q <= 1'b0;
                            if (state == I_RD) begin
                                i_resp_q <= 1'b1;
                            end else begin
                                d_resp_q <= 1'b1;
                            end
                        end else begin
                            beat <= beat + CW'(1);
                        end
                    end
                end
                DONE: begin
                    i_resp_q <= 1'b0;
                    d_resp_q <= 1'b0;
                    last_d   <= d_resp_q;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_read  = pmem_read_q;
    assign bus.pmem_write = pmem_write_q;
    assign bus.pmem_addr  = addr_q;
    // Write beats come straight out of the line buffer so beat 0 is valid from burst start
    assign bus.pmem_wdata = (pmem_write_q && in_burst)
                            ? line_buf[beat_idx*BURST_WIDTH +: BURST_WIDTH] : '0;
    assign bus.i_resp     = i_resp_q;
    assign bus.d_resp     = d_resp_q;
    assign bus.i_rdata    = i_resp_q ? line_buf : '0;
    assign bus.d_rdata    = d_resp_q ? line_buf : '0;
    assign bus.arb_error  = arb_error_q;
endmodule
